// File: rtl/fft_pkg.sv
// fft_pkg
// Definitions shared by the FFT frame sequencer and its helpers.
//   DEF_DATA_W / DEF_N_POINT / DEF_LATENCY : default sample width, FFT size
//                                            and FFT pipeline latency
//   state_e    : sequencer states (IDLE / RUN / DRAIN)
//   sample_t   : one complex sample {re, im}
//   bit_reverse: reverses the low 'width' bits of a 16-bit value
package fft_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_N_POINT = 128;
  localparam int DEF_LATENCY = 268;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } sample_t;

  // Shift the value out LSB-first into the result, one bit per index bit,
  // so the low 'width' bits of the result hold the mirrored index.
  function automatic logic [15:0] bit_reverse(input logic [15:0] value, input int width);
    logic [15:0] v;
    logic [15:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) begin
        r = {r[14:0], v[0]};
        v = {1'b0, v[15:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_inflight_q.sv
// fft_inflight_q
// Small circular FIFO of frame start timestamps. One entry per frame that
// has been handed to the FFT but has not yet finished leaving it.
//   clk, reset : clock, asynchronous active-high reset (empties the queue)
//   push       : store push_ts as the newest entry
//   push_ts    : timestamp of the frame just started
//   pop        : drop the oldest entry
//   head       : oldest timestamp (meaningful only when empty is low)
//   empty      : no frames in flight
module fft_inflight_q #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_ts,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; entries are only read while the count says
  // they hold a live timestamp.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_ts;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // The depth is sized so the sequencer can never have more frames in
  // flight than there are slots.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Frame sequencer around an FFT core: feeds the FFT gap-free with N_POINT
// samples per frame (start pulse on sample 0), follows every frame through
// the fixed FFT latency, and tags the FFT output with first/last/index.
// Runs cfg_frames frames (0 = until stop), drains, then pulses done.
//
// Build option: define FFT_FRAME_CTRL_BITREV_EN to make m_index the
// bit-reversed output sample count (bit-reversed-order FFT output);
// otherwise m_index counts 0..N_POINT-1.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   go, stop, cfg_frames  : run control (go in IDLE, stop in RUN)
//   busy, done            : RUN/DRAIN indicator, end-of-run pulse
//   err_underrun          : sticky, a slot was issued without s_valid
//   frames_done           : output frames completed this run
//   s_valid/s_ready/s_re/s_im           : upstream sample stream
//   fft_start/fft_valid/fft_re/fft_im   : FFT input side (registered)
//   fft_out_re/fft_out_im               : FFT outputs
//   m_valid/m_first/m_last/m_index      : output tags (registered)
//   m_re/m_im                           : FFT outputs gated by m_valid
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINT = DEF_N_POINT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY,
  localparam int IDX_W  = $clog2(N_POINT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              stop,
  input  logic [15:0]       cfg_frames,
  output logic              busy,
  output logic              done,
  output logic              err_underrun,
  output logic [15:0]       frames_done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_re,
  input  logic [DATA_W-1:0] s_im,
  output logic              fft_start,
  output logic              fft_valid,
  output logic [DATA_W-1:0] fft_re,
  output logic [DATA_W-1:0] fft_im,
  input  logic [DATA_W-1:0] fft_out_re,
  input  logic [DATA_W-1:0] fft_out_im,
  output logic              m_valid,
  output logic              m_first,
  output logic              m_last,
  output logic [IDX_W-1:0]  m_index,
  output logic [DATA_W-1:0] m_re,
  output logic [DATA_W-1:0] m_im
);

  localparam int TS_W    = $clog2(LATENCY + N_POINT) + 1;
  localparam int Q_DEPTH = LATENCY / N_POINT + 2;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]       state;
  logic [IDX_W-1:0] slot;
  logic [15:0]      cfg_lat;
  logic [15:0]      frames_issued;
  logic [15:0]      issued_next;
  logic             stop_lat;
  logic             in_run;
  logic             slot_last;
  logic             run_end;
  logic             drain_end;
  logic             go_accept;

  logic [TS_W-1:0]  ts_cnt;
  logic [TS_W-1:0]  ts_diff;
  logic             q_push;
  logic             q_pop;
  logic [TS_W-1:0]  q_head;
  logic             q_empty;

  logic             emitting;
  logic [IDX_W-1:0] emit_cnt;
  logic [IDX_W-1:0] emit_idx;
  logic [IDX_W-1:0] out_idx;
  logic             start_hit;
  logic             emit;
  logic             emit_last;

  assign in_run      = (state == S_RUN);
  assign go_accept   = (state == S_IDLE) && go;
  assign busy        = (state != S_IDLE);
  assign s_ready     = in_run;
  assign slot_last   = (slot == IDX_W'(N_POINT - 1));
  assign issued_next = frames_issued + 16'd1;
  // A stop arriving on the last slot itself still ends the run after it.
  assign run_end     = in_run && slot_last &&
                       (((cfg_lat != 16'd0) && (issued_next == cfg_lat)) || stop_lat || stop);

  // The timestamp recorded for a frame is the counter value on the edge that
  // issues its slot 0, so the first output sample is due exactly LATENCY
  // counts later. Modular subtraction makes counter wrap harmless.
  assign q_push    = in_run && (slot == '0);
  assign ts_diff   = ts_cnt - q_head;
  assign start_hit = !emitting && !q_empty && (ts_diff == TS_W'(LATENCY));
  assign emit      = emitting || start_hit;
  assign emit_idx  = emitting ? emit_cnt : '0;
  assign emit_last = emit && (emit_idx == IDX_W'(N_POINT - 1));
  assign q_pop     = emit_last;
  // The head is popped together with m_last being registered, so an empty
  // queue while m_last is visible means the final frame has left.
  assign drain_end = (state == S_DRAIN) && m_last && q_empty;

`ifdef FFT_FRAME_CTRL_BITREV_EN
  assign out_idx = IDX_W'(bit_reverse(16'(emit_idx), IDX_W));
`else
  assign out_idx = emit_idx;
`endif

  assign m_re = m_valid ? fft_out_re : '0;
  assign m_im = m_valid ? fft_out_im : '0;

  fft_inflight_q #(
    .DEPTH (Q_DEPTH),
    .W     (TS_W)
  ) u_inflight_q (
    .clk     (clk),
    .reset   (reset),
    .push    (q_push),
    .push_ts (ts_cnt),
    .pop     (q_pop),
    .head    (q_head),
    .empty   (q_empty)
  );

  // Input side: run-control FSM and the gap-free FFT feed. Every RUN cycle
  // issues a slot; a missing upstream sample is replaced by zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      slot          <= '0;
      cfg_lat       <= '0;
      frames_issued <= '0;
      stop_lat      <= 1'b0;
      err_underrun  <= 1'b0;
      done          <= 1'b0;
      fft_start     <= 1'b0;
      fft_valid     <= 1'b0;
      fft_re        <= '0;
      fft_im        <= '0;
    end else begin
      done      <= 1'b0;
      fft_start <= 1'b0;
      fft_valid <= 1'b0;
      fft_re    <= '0;
      fft_im    <= '0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state         <= S_RUN;
            cfg_lat       <= cfg_frames;
            err_underrun  <= 1'b0;
            slot          <= '0;
            frames_issued <= '0;
            stop_lat      <= 1'b0;
          end
        end
        S_RUN: begin
          fft_valid <= 1'b1;
          fft_start <= (slot == '0);
          if (s_valid) begin
            fft_re <= s_re;
            fft_im <= s_im;
          end else begin
            err_underrun <= 1'b1;
          end
          slot <= slot + 1'b1;
          if (stop) begin
            stop_lat <= 1'b1;
          end
          if (slot_last) begin
            frames_issued <= issued_next;
            stop_lat      <= 1'b0;
            if (run_end) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output side: free-running timestamp counter and output frame tagging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt      <= '0;
      emitting    <= 1'b0;
      emit_cnt    <= '0;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      m_index     <= '0;
      frames_done <= '0;
    end else begin
      ts_cnt  <= ts_cnt + 1'b1;
      m_valid <= emit;
      m_first <= emit && (emit_idx == '0);
      m_last  <= emit_last;
      m_index <= emit ? out_idx : '0;
      if (emit) begin
        emitting <= !emit_last;
        emit_cnt <= emit_idx + 1'b1;
      end
      if (go_accept) begin
        frames_done <= '0;
      end else if (emit_last) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
// Randomised self-checking bench for fft_frame_ctrl. Expected outputs for
// every cycle are derived from the run parameters (frame count, stop point,
// upstream valid pattern) with plain cycle arithmetic.
module tb_fft_frame_ctrl;

  localparam int N    = 128;
  localparam int L    = 268;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_frames = '0;
  logic        busy, done, err_underrun;
  logic [15:0] frames_done;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_re = '0, s_im = '0;
  logic        fft_start, fft_valid;
  logic [15:0] fft_re, fft_im;
  logic [15:0] fft_out_re = '0, fft_out_im = '0;
  logic        m_valid, m_first, m_last;
  logic [6:0]  m_index;
  logic [15:0] m_re, m_im;

  int assert_count = 0;
  int fail_count = 0;

  bit          sv  [MAXC];
  logic [15:0] sre [MAXC];
  logic [15:0] sim [MAXC];

  fft_frame_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .stop         (stop),
    .cfg_frames   (cfg_frames),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun),
    .frames_done  (frames_done),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_re         (s_re),
    .s_im         (s_im),
    .fft_start    (fft_start),
    .fft_valid    (fft_valid),
    .fft_re       (fft_re),
    .fft_im       (fft_im),
    .fft_out_re   (fft_out_re),
    .fft_out_im   (fft_out_im),
    .m_valid      (m_valid),
    .m_first      (m_first),
    .m_last       (m_last),
    .m_index      (m_index),
    .m_re         (m_re),
    .m_im         (m_im)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_ctrl(bit b, bit d, bit e, bit r, bit fs, bit fv,
                                            bit mv, bit mf, bit ml, logic [15:0] fd, logic [7:0] idx);
    return {31'b0, b, d, e, r, fs, fv, mv, mf, ml, fd, idx};
  endfunction

  function automatic logic [63:0] obs_ctrl();
    return pack_ctrl(busy, done, err_underrun, s_ready, fft_start, fft_valid,
                     m_valid, m_first, m_last, frames_done, {1'b0, m_index});
  endfunction

  function automatic logic [63:0] obs_data();
    return {fft_re, fft_im, m_re, m_im};
  endfunction

  // Output position n within a frame, mapped to the expected index tag.
  function automatic logic [7:0] index_model(int n);
    int r;
    r = n;
`ifdef FFT_FRAME_CTRL_BITREV_EN
    r = 0;
    for (int b = 0; b < 7; b++) begin
      if ((n >> b) & 1) r = r + (1 << (6 - b));
    end
`endif
    return 8'(r);
  endfunction

  // One run: go at cycle 0, stimulus and checks every cycle up to a few
  // cycles past done (or up to abort_cycle). Cycle c means the value seen
  // by the rising edge numbered c.
  task automatic applyStimulus(input int cfg, input int stop_frame, input int stop_slot,
                               input int underrun_mode, input int abort_cycle, input bit noise);
    int frames, done_c, last_c;
    bit err_run;
    bit b, d, r, fs, fv, mv, mf, ml;
    int n, fd;
    logic [15:0] fre, fim, mre, mim;
    logic [7:0] idx;

    if (stop_frame >= 0 && (cfg == 0 || stop_frame < cfg)) frames = stop_frame + 1;
    else frames = cfg;
    done_c = 2 + L + N * frames;
    last_c = (abort_cycle >= 0) ? abort_cycle : done_c + 3;

    for (int c = 0; c <= last_c; c++) begin
      sv[c]  = 1'b1;
      sre[c] = 16'($urandom);
      sim[c] = 16'($urandom);
      if (underrun_mode == 1 && c == 6) sv[c] = 1'b0;
      if (underrun_mode == 2 && $urandom_range(0, 7) == 0) sv[c] = 1'b0;
    end

    err_run = 1'b0;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      go         = (c == 0) ? 1'b1 : (noise && c < done_c) ? 1'($urandom) : 1'b0;
      cfg_frames = (c == 0) ? 16'(cfg) : 16'($urandom);
      if (stop_frame >= 0 && c == 1 + N * stop_frame + stop_slot) stop = 1'b1;
      else if (noise && (c == 0 || c > N * frames) && c < done_c) stop = 1'($urandom);
      else stop = 1'b0;
      s_valid    = sv[c];
      s_re       = sre[c];
      s_im       = sim[c];
      fft_out_re = 16'($urandom);
      fft_out_im = 16'($urandom);
      #1;
      if (c >= 1) begin
        b  = (c < done_c);
        d  = (c == done_c);
        r  = (c <= N * frames);
        fv = (c >= 2 && c <= N * frames + 1);
        fs = fv && ((c - 2) % N == 0);
        fre = (fv && sv[c-1]) ? sre[c-1] : 16'h0;
        fim = (fv && sv[c-1]) ? sim[c-1] : 16'h0;
        mv = (c >= 2 + L && c < 2 + L + N * frames);
        n  = mv ? (c - 2 - L) % N : 0;
        mf = mv && n == 0;
        ml = mv && n == N - 1;
        idx = mv ? index_model(n) : 8'h0;
        mre = mv ? fft_out_re : 16'h0;
        mim = mv ? fft_out_im : 16'h0;
        fd = 0;
        for (int k = 0; k < frames; k++) begin
          if (2 + L + N * k + N - 1 <= c) fd++;
        end
        checkOutput("ctrl", obs_ctrl(), pack_ctrl(b, d, err_run, r, fs, fv, mv, mf, ml, 16'(fd), idx));
        checkOutput("data", obs_data(), {fre, fim, mre, mim});
        if (c <= N * frames && !sv[c]) err_run = 1'b1;
      end
    end
    go   = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    int cfg, sf;
    $display("[TB] fft_frame_ctrl bench start");
    repeat (3) @(negedge clk);
    fft_out_re = 16'hA5A5;
    fft_out_im = 16'h5A5A;
    #1;
    checkOutput("reset_ctrl", obs_ctrl(), 64'h0);
    checkOutput("reset_data", obs_data(), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single frame");
    applyStimulus(1, -1, 0, 0, -1, 1'b0);
    $display("[TB] three frames");
    applyStimulus(3, -1, 0, 0, -1, 1'b0);
    $display("[TB] underrun in slot 5");
    applyStimulus(1, -1, 0, 1, -1, 1'b0);
    $display("[TB] continuous with stop in frame 1");
    applyStimulus(0, 1, 40, 2, -1, 1'b1);
    $display("[TB] stop on last slot");
    applyStimulus(0, 0, N - 1, 0, -1, 1'b0);
    $display("[TB] stop and count end in same frame");
    applyStimulus(2, 1, 10, 0, -1, 1'b0);

    $display("[TB] reset mid-run");
    applyStimulus(3, -1, 0, 0, 200, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_ctrl", obs_ctrl(), 64'h0);
    checkOutput("midrun_reset_data", obs_data(), 64'h0);
    @(negedge clk);
    checkOutput("held_reset_ctrl", obs_ctrl(), 64'h0);
    reset = 1'b0;
    applyStimulus(1, -1, 0, 0, -1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      cfg = $urandom_range(0, 3);
      if (cfg == 0) sf = $urandom_range(0, 2);
      else sf = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, 2);
      $display("[TB] random run cfg=%0d stop_frame=%0d", cfg, sf);
      applyStimulus(cfg, sf, $urandom_range(0, N - 1), 2, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer that sits in front of and behind `Top_FFT`. It accepts a sample stream with a valid/ready handshake and feeds the FFT gap-free, N_POINT samples per frame, with a `start` pulse on every frame's sample 0. It tracks in-flight frames across the FFT's fixed pipeline latency and tags the output stream with first/last/index markers. It runs a configured number of frames (or runs until stopped), drains the pipeline, then signals done.

## Interface
- `N_POINT`, 128, FFT size; power of 2. `IDX_W = $clog2(N_POINT)`.
- `DATA_W`, 16, real/imag sample width.
- `LATENCY`, 268, cycles from an `fft_start` cycle to the first output sample of that frame.
- `clk` in 1, single clock.
- `reset` in 1, reset is asynchronous and active-high.
- `go` in 1, start a run; honoured in IDLE only.
- `stop` in 1, end the run at the next frame boundary; honoured in RUN only.
- `cfg_frames` in 16, frames per run; 0 means continuous. Sampled on `go`.
- `busy` out 1, high in RUN and DRAIN.
- `done` out 1, one-cycle pulse at the end of a run.
- `err_underrun` out 1, sticky; cleared on an accepted `go`.
- `frames_done` out 16, output frames completed this run.
- `s_valid` in 1, `s_ready` out 1, `s_re`/`s_im` in DATA_W: upstream samples.
- `fft_start` out 1, `fft_valid` out 1, `fft_re`/`fft_im` out DATA_W: FFT input side.
- `fft_out_re`/`fft_out_im` in DATA_W: FFT outputs.
- `m_valid`, `m_first`, `m_last` out 1; `m_index` out IDX_W; `m_re`/`m_im` out DATA_W: tagged output.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on `go`. On that transition the block latches `cfg_frames`, clears `err_underrun` and clears `frames_done`.
- RUN:
  - `s_ready`=1 every cycle, and one sample slot is issued per cycle.
  - Slot n of a frame is a handshake sample if `s_valid`=1.
  - If `s_valid`=0, the slot carries zeros and `err_underrun` is set. The FFT never sees a gap.
  - The next frame's slot 0 follows slot N_POINT-1 immediately.
- RUN → DRAIN after slot N_POINT-1 when either condition holds:
  - the issued frame count equals the latched `cfg_frames` (and it is non-zero), or
  - `stop` was seen during the frame. `stop` is latched; the current frame always completes.
- DRAIN:
  - `s_ready`=0, `fft_valid`=0, `fft_re`/`fft_im`=0.
  - DRAIN → IDLE the cycle after the last in-flight frame's `m_last`. That cycle has `done`=1 and `busy`=0.
- In-flight tracking:
  - A free-running `TS_W`-bit cycle counter runs, with `TS_W = $clog2(LATENCY+N_POINT)+1`.
  - On each `fft_start`, the counter value is pushed into a queue of depth `LATENCY/N_POINT+2`.
  - Output frame begins when `(cnt - head) mod 2^TS_W == LATENCY`. The head is popped after that frame's `m_last`.
  - Queue overflow is unreachable; it is covered by a simulation assertion.
- Output tagging:
  - `m_valid` is high for N_POINT consecutive cycles per frame.
  - `m_first` on index 0, `m_last` on index N_POINT-1.
  - `frames_done` increments on `m_last`.
  - `m_re`/`m_im` = `fft_out_re`/`fft_out_im` when `m_valid`=1, else 0.
- Ignored inputs: `go` outside IDLE; `stop` outside RUN.

## Timing
- Reset values: all outputs 0, state IDLE, queue empty, counters 0. Reset acts immediately on assertion, including mid-frame and mid-drain.
- `go` sampled at cycle 0:
  - state RUN and `s_ready`=1 from cycle 1;
  - sample accepted at cycle t appears on `fft_*` at t+1, so the first `fft_start` is at cycle 2.
- `fft_start` at cycle T gives `m_first` at T+LATENCY and `m_last` at T+LATENCY+N_POINT-1.
- All FFT-side outputs and `m_first`/`m_last`/`m_index`/`m_valid` are registered. `m_re`/`m_im` are combinational from `fft_out_*`, gated by `m_valid`.
- Simultaneous events: `stop` on the last slot of a frame ends the run after that frame. Frame-count completion and `stop` in the same frame give a single transition.

## Configuration
- `FFT_FRAME_CTRL_BITREV_EN`:
  - defined: `m_index` is the IDX_W-bit bit-reversal of the output sample count, matching a bit-reversed-order FFT output;
  - undefined: `m_index` is the natural count 0..N_POINT-1.
- First/last marking and all timing are identical in both builds.

## Structure
- Shared package `fft_pkg`: state enum (IDLE/RUN/DRAIN), `DATA_W`, `N_POINT`, `LATENCY` defaults, and a sample struct {re, im}.
- Sub-module `fft_inflight_q`: the timestamp queue with push, pop, head and an empty flag.

## Test plan
- **Single frame:** `go` at cycle 0, `cfg_frames`=1, `s_valid`=1, ramp data.
  - `s_ready` high cycles 1–128 and low from 129.
  - `fft_start` at 2; `m_first` at 270, `m_last` at 397.
  - `done` at 398; `frames_done`=1.
- **Three frames back-to-back:** `cfg_frames`=3.
  - `fft_start` at 2, 130, 258, with `fft_valid` continuous 2–385.
  - `m_first` at 270, 398, 526; `done` at 654; `frames_done`=3.
- **Underrun:** `s_valid`=0 on slot 5 of frame 0.
  - `fft_valid`=1 with `fft_re`=`fft_im`=0 in that slot.
  - `err_underrun`=1 until the next `go`; frame timing unchanged.
- **Continuous with stop:** `cfg_frames`=0, `stop` pulsed at slot 40 of frame 1.
  - Frame 1 completes and exactly 2 frames are output; `done` at 526.
- **Reset mid-run:** `reset` asserted during frame 1.
  - All outputs 0 immediately; the queue is empty.
  - A following `go` reproduces the single-frame timings relative to the new `go`.
- **Index order:** with `FFT_FRAME_CTRL_BITREV_EN`, `m_index` = 0, 64, 32, 96, …; without it, 0, 1, 2, 3, ….
